// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared mode encoding and direction constants for pwm_multi
package pwm_pkg;

  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_UPDOWN = 2'd2
  } mode_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_ch.sv
// rtl/pwm_ch.sv - one PWM channel: shadowed compare/polarity and registered output
module pwm_ch #(
  parameter int W = 5
) (
  input  logic         clk50m,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] cnt_next,
  input  logic [W-1:0] cmp,
  input  logic         pol,
  output logic         pwm
);

  logic [W-1:0] cmp_a_q, cmp_a_d;
  logic         pol_a_q, pol_a_d;
  logic         pwm_q, pwm_d;

  // Output is computed from the values the counter is about to take, so it never lags cnt.
  always_comb begin
    cmp_a_d = load ? cmp : cmp_a_q;
    pol_a_d = load ? pol : pol_a_q;
    pwm_d   = pwm_q;
    if (en) begin
      pwm_d = (cnt_next < cmp_a_d) ^ pol_a_d;
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      cmp_a_q <= '0;
      pol_a_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      cmp_a_q <= cmp_a_d;
      pol_a_q <= pol_a_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - N-channel PWM on a shared up/down/centre-aligned timebase with boundary-synchronous reload
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int W = 5,
  parameter int N = 4
) (
  input  logic                clk50m,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [W-1:0]        per,
  input  logic [N-1:0][W-1:0] cmp,
  input  logic [N-1:0]        pol,
  input  logic                upd,
  output logic [W-1:0]        cnt,
  output logic                dir,
  output logic [N-1:0]        pwm,
  output logic                evt,
  output logic                upd_pend
);

  localparam logic [W-1:0] ZERO = '0;
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] per_a_q, per_a_d;
  logic [1:0]   mode_a_q, mode_a_d;
  logic         dir_q, dir_d;
  logic         upd_pend_q, upd_pend_d;
  logic         bnd;
  logic         load;

  always_comb begin
    bnd = 1'b0;
    case (mode_t'(mode_a_q))
      MODE_DOWN:   bnd = (cnt_q == ZERO);
      MODE_UPDOWN: bnd = (cnt_q == ZERO) && (dir_q == DIR_DOWN || per_a_q == ZERO);
      default:     bnd = (cnt_q == per_a_q);
    endcase
  end

  assign load = en && bnd && (upd_pend_q || upd);

  always_comb begin
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    per_a_d    = per_a_q;
    mode_a_d   = mode_a_q;
    upd_pend_d = upd_pend_q;
    if (upd) begin
      upd_pend_d = 1'b1;
    end
    if (load) begin
      // New period starts immediately from the freshly loaded shadows.
      upd_pend_d = 1'b0;
      per_a_d    = per;
      mode_a_d   = mode;
      if (mode_t'(mode) == MODE_DOWN) begin
        cnt_d = per;
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = ZERO;
        dir_d = DIR_UP;
      end
    end else if (en) begin
      case (mode_t'(mode_a_q))
        MODE_DOWN: begin
          dir_d = DIR_DOWN;
          cnt_d = bnd ? per_a_q : cnt_q - ONE;
        end
        MODE_UPDOWN: begin
          if (dir_q == DIR_UP && cnt_q == per_a_q) begin
            dir_d = DIR_DOWN;
            cnt_d = (per_a_q == ZERO) ? ZERO : cnt_q - ONE;
          end else if (bnd) begin
            dir_d = DIR_UP;
            cnt_d = (per_a_q == ZERO) ? ZERO : ONE;
          end else begin
            cnt_d = (dir_q == DIR_DOWN) ? cnt_q - ONE : cnt_q + ONE;
          end
        end
        default: begin
          dir_d = DIR_UP;
          cnt_d = bnd ? ZERO : cnt_q + ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= ZERO;
      dir_q      <= DIR_UP;
      per_a_q    <= '1;
      mode_a_q   <= MODE_UP;
      upd_pend_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      per_a_q    <= per_a_d;
      mode_a_q   <= mode_a_d;
      upd_pend_q <= upd_pend_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    pwm_ch #(.W(W)) u_ch (
      .clk50m   (clk50m),
      .rst_n    (rst_n),
      .load     (load),
      .en       (en),
      .cnt_next (cnt_d),
      .cmp      (cmp[i]),
      .pol      (pol[i]),
      .pwm      (pwm[i])
    );
  end

  assign cnt      = cnt_q;
  assign dir      = dir_q;
  assign evt      = bnd && en;
  assign upd_pend = upd_pend_q;

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - directed table and sequence bench for pwm_multi
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int W = 5;
  localparam int N = 4;

  logic                clk50m = 1'b0;
  logic                rst_n;
  logic                en;
  logic [1:0]          mode;
  logic [W-1:0]        per;
  logic [N-1:0][W-1:0] cmp;
  logic [N-1:0]        pol;
  logic                upd;
  logic [W-1:0]        cnt;
  logic                dir;
  logic [N-1:0]        pwm;
  logic                evt;
  logic                upd_pend;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic       en;
    logic       upd;
    logic [1:0] mode;
    logic [W-1:0] per;
    logic [W-1:0] cmp0;
    logic       pol0;
    int         cnt;
    int         dir;
    int         pwm0;
    int         evt;
    int         pend;
  } vec_t;

  vec_t tv[$];

  always #10 clk50m = ~clk50m;

  pwm_multi #(.W(W), .N(N)) dut (
    .clk50m   (clk50m),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .per      (per),
    .cmp      (cmp),
    .pol      (pol),
    .upd      (upd),
    .cnt      (cnt),
    .dir      (dir),
    .pwm      (pwm),
    .evt      (evt),
    .upd_pend (upd_pend)
  );

  function automatic vec_t v(input int e, u, m, p, c, o, cn, d, pw, ev, pd);
    vec_t r;
    r.en   = e[0];
    r.upd  = u[0];
    r.mode = 2'(m);
    r.per  = W'(p);
    r.cmp0 = W'(c);
    r.pol0 = o[0];
    r.cnt  = cn;
    r.dir  = d;
    r.pwm0 = pw;
    r.evt  = ev;
    r.pend = pd;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs are already driven; sample outputs just after the falling edge, then advance one cycle.
  task automatic cyc(input string tag, input int e_cnt, input int e_dir,
                     input logic [N-1:0] e_pwm, input logic [N-1:0] m_pwm,
                     input int e_evt, input int e_pend);
    #1;
    chk({tag, ".cnt"},  int'(cnt), e_cnt);
    chk({tag, ".dir"},  int'(dir), e_dir);
    chk({tag, ".pwm"},  int'(pwm & m_pwm), int'(e_pwm & m_pwm));
    chk({tag, ".evt"},  int'(evt), e_evt);
    chk({tag, ".pend"}, int'(upd_pend), e_pend);
    @(negedge clk50m);
  endtask

  initial begin
    int highs;
    int c;
    logic [N-1:0] ep;

    // down mode with inversion, then centre-aligned
    for (int i = 0; i < 18; i++) tv.push_back(v(1, 0, 1, 7, 2, 1, 0, 0, 0, 0, 0));
    tv[0]  = v(1, 0, 1, 7, 2, 1, 0, 0, 1, 0, 0);
    tv[1]  = v(1, 1, 1, 7, 2, 1, 1, 0, 1, 0, 0);
    tv[2]  = v(1, 0, 1, 7, 2, 1, 2, 0, 1, 0, 1);
    tv[3]  = v(1, 0, 1, 7, 2, 1, 3, 0, 0, 0, 1);
    tv[4]  = v(1, 0, 1, 7, 2, 1, 4, 0, 0, 0, 1);
    tv[5]  = v(1, 0, 1, 7, 2, 1, 5, 0, 0, 0, 1);
    tv[6]  = v(1, 0, 1, 7, 2, 1, 6, 0, 0, 0, 1);
    tv[7]  = v(1, 0, 1, 7, 2, 1, 7, 0, 0, 0, 1);
    tv[8]  = v(1, 0, 1, 7, 2, 1, 8, 0, 0, 0, 1);
    tv[9]  = v(1, 0, 1, 7, 2, 1, 9, 0, 0, 1, 1);
    tv[10] = v(1, 0, 1, 7, 2, 1, 7, 1, 1, 0, 0);
    tv[11] = v(1, 0, 1, 7, 2, 1, 6, 1, 1, 0, 0);
    tv[12] = v(1, 0, 1, 7, 2, 1, 5, 1, 1, 0, 0);
    tv[13] = v(1, 0, 1, 7, 2, 1, 4, 1, 1, 0, 0);
    tv[14] = v(1, 0, 1, 7, 2, 1, 3, 1, 1, 0, 0);
    tv[15] = v(1, 0, 1, 7, 2, 1, 2, 1, 1, 0, 0);
    tv[16] = v(1, 0, 1, 7, 2, 1, 1, 1, 0, 0, 0);
    tv[17] = v(1, 0, 1, 7, 2, 1, 0, 1, 0, 1, 0);
    tv.push_back(v(1, 1, 2, 4, 2, 0, 7, 1, 1, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 6, 1, 1, 0, 1));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 5, 1, 1, 0, 1));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 4, 1, 1, 0, 1));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 3, 1, 1, 0, 1));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 2, 1, 1, 0, 1));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 1, 1, 0, 0, 1));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 0, 1, 0, 1, 1));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 0, 0, 1, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 1, 0, 1, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 2, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 3, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 4, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 3, 1, 0, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 2, 1, 0, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 1, 1, 1, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 0, 1, 1, 1, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 1, 0, 1, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 2, 0, 0, 0, 0));
    tv.push_back(v(1, 0, 2, 4, 2, 0, 3, 0, 0, 0, 0));

    rst_n = 1'b0;
    en    = 1'b0;
    upd   = 1'b0;
    mode  = 2'(MODE_UP);
    per   = '0;
    cmp   = '0;
    pol   = '0;
    repeat (2) @(negedge clk50m);
    rst_n = 1'b1;

    // up mode: reset period 31 runs first, then the pending load switches to per 9
    per = 5'd9;
    cmp = {5'd0, 5'd12, 5'd5, 5'd3};
    en  = 1'b1;
    for (int k = 0; k < 52; k++) begin
      upd = (k == 0);
      if (k < 32) begin
        cyc($sformatf("up%0d", k), k, 0, '0, '1, int'(k == 31), int'(k >= 1));
      end else begin
        c = (k - 32) % 10;
        ep = {1'b0, 1'b1, 1'(c < 5), 1'(c < 3)};
        cyc($sformatf("up%0d", k), c, 0, ep, '1, int'(c == 9), 0);
      end
    end

    for (int i = 0; i < tv.size(); i++) begin
      en     = tv[i].en;
      upd    = tv[i].upd;
      mode   = tv[i].mode;
      per    = tv[i].per;
      cmp[0] = tv[i].cmp0;
      pol[0] = tv[i].pol0;
      cyc($sformatf("tbl%0d", i), tv[i].cnt, tv[i].dir, N'(tv[i].pwm0), 4'b0001,
          tv[i].evt, tv[i].pend);
    end
    upd = 1'b0;

    // back to up mode from the top of the centre-aligned ramp
    mode = 2'(MODE_UP);
    per = 5'd9;
    cmp[0] = 5'd3;
    pol[0] = 1'b0;
    upd = 1'b1;
    cyc("t4a", 4, 0, 4'b0000, 4'b0001, 0, 0);
    upd = 1'b0;
    cyc("t4b", 3, 1, 4'b0000, 4'b0001, 0, 1);
    cyc("t4c", 2, 1, 4'b0000, 4'b0001, 0, 1);
    cyc("t4d", 1, 1, 4'b0001, 4'b0001, 0, 1);
    cyc("t4e", 0, 1, 4'b0001, 4'b0001, 1, 1);

    // shadowing: staged cmp0 = 6 ignored until upd lands on the boundary
    cmp[0] = 5'd6;
    for (int i = 0; i < 50; i++) begin
      upd = (i == 39);
      c = i % 10;
      ep = '0;
      ep[0] = (i >= 40) ? (c < 6) : (c < 3);
      cyc($sformatf("shd%0d", i), c, 0, ep, 4'b0001, int'(c == 9), 0);
    end
    upd = 1'b0;

    // enable freeze at the boundary count
    for (int j = 0; j < 9; j++) begin
      cyc($sformatf("ena%0d", j), j, 0, N'(j < 6), 4'b0001, 0, 0);
    end
    en = 1'b0;
    for (int f = 0; f < 5; f++) begin
      upd = (f == 0);
      cyc($sformatf("frz%0d", f), 9, 0, 4'b0000, 4'b0001, 0, int'(f >= 1));
    end
    upd = 1'b0;
    en  = 1'b1;
    cyc("thaw", 9, 0, 4'b0000, 4'b0001, 1, 1);
    cyc("run0", 0, 0, 4'b0001, 4'b0001, 0, 0);
    cyc("run1", 1, 0, 4'b0001, 4'b0001, 0, 0);
    cyc("run2", 2, 0, 4'b0001, 4'b0001, 0, 0);
    upd = 1'b1;
    cyc("run3", 3, 0, 4'b0001, 4'b0001, 0, 0);
    upd = 1'b0;
    cyc("run4", 4, 0, 4'b0001, 4'b0001, 0, 1);

    // asynchronous reset mid-period, between clock edges
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst.cnt",  int'(cnt), 0);
    chk("rst.dir",  int'(dir), 0);
    chk("rst.pwm",  int'(pwm), 0);
    chk("rst.evt",  int'(evt), 0);
    chk("rst.pend", int'(upd_pend), 0);
    @(negedge clk50m);
    rst_n = 1'b1;

    // reset period is 31; at its boundary load per 0 / cmp0 1
    per = 5'd0;
    cmp[0] = 5'd1;
    for (int k = 0; k < 32; k++) begin
      upd = (k == 31);
      cyc($sformatf("rp%0d", k), k, 0, '0, '1, int'(k == 31), 0);
    end
    upd = 1'b0;
    cyc("p0a", 0, 0, 4'b0001, 4'b0001, 1, 0);
    cyc("p0b", 0, 0, 4'b0001, 4'b0001, 1, 0);
    per = 5'd31;
    cmp[0] = 5'd31;
    upd = 1'b1;
    cyc("p0c", 0, 0, 4'b0001, 4'b0001, 1, 0);
    upd = 1'b0;

    highs = 0;
    for (int k = 0; k < 34; k++) begin
      c = k % 32;
      if (k < 32 && pwm[0]) highs++;
      cyc($sformatf("p31_%0d", k), c, 0, N'(c < 31), 4'b0001, int'(c == 31), 0);
    end
    chk("p31.duty", highs, 31);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
